// File: rtl/slow_clk_pkg.sv
// Shared types and default constants for the slow clock monitor.
package slow_clk_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOST    = 2'd2
    } state_e;

    localparam logic [1:0] ST_IDLE    = 2'(IDLE);
    localparam logic [1:0] ST_MEASURE = 2'(MEASURE);
    localparam logic [1:0] ST_LOST    = 2'(LOST);

    localparam int          CNT_W_DEF       = 32;
    localparam int unsigned TIMEOUT_DEF     = 200_000_000;
    localparam int          SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/sync_edge_det.sv
// Synchronizes an asynchronous level into clk_in and produces one-cycle rise/fall pulses.
module sync_edge_det
    import slow_clk_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic d_in,
    output logic level_out,
    output logic rise_out,
    output logic fall_out
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // The extra prev_q flop sits after the synchronizer purely for edge detection.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_out = sync_q[SYNC_STAGES-1];
    assign rise_out  = level_out & ~prev_q;
    assign fall_out  = ~level_out & prev_q;

endmodule

// File: rtl/slow_clk_monitor.sv
// Measures period (and high time when SLOW_CLK_MON_DUTY_EN is defined) of a slow clock
// in clk_in cycles, with valid/ack result handshake and loss-of-clock detection.
module slow_clk_monitor
    import slow_clk_pkg::*;
#(
    parameter int          CNT_W       = CNT_W_DEF,
    parameter int unsigned TIMEOUT     = TIMEOUT_DEF,
    parameter int          SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             slow_in,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic             valid_out,
    input  logic             ack_in,
    output logic             overrun_out,
    output logic             lost_out
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    logic             level_unused;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       state;
    logic             cnt_sat;
    logic             new_result;
    logic             lost_evt;
    logic             accepted;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .d_in      (slow_in),
        .level_out (level_unused),
        .rise_out  (rise),
        .fall_out  (fall)
    );

    assign cnt_sat    = (cnt == TIMEOUT_C);
    assign new_result = (state == ST_MEASURE) && rise;
    assign lost_evt   = (state == ST_MEASURE) && !rise && cnt_sat;
    assign accepted   = valid_out && ack_in;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (rise) begin
            cnt <= CNT_W'(1);
        end else if (!cnt_sat) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // A rise coinciding with saturation counts as a normal edge, so rise is checked first.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            lost_out <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rise) state <= ST_MEASURE;
                end
                ST_MEASURE: begin
                    if (lost_evt) begin
                        state    <= ST_LOST;
                        lost_out <= 1'b1;
                    end
                end
                ST_LOST: begin
                    if (rise) begin
                        state    <= ST_MEASURE;
                        lost_out <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            period_out  <= '0;
            valid_out   <= 1'b0;
            overrun_out <= 1'b0;
        end else if (new_result) begin
            period_out <= cnt;
            valid_out  <= 1'b1;
            if (valid_out && !ack_in) begin
                overrun_out <= 1'b1;
            end else if (accepted) begin
                overrun_out <= 1'b0;
            end
        end else begin
            if (lost_evt || accepted) valid_out <= 1'b0;
            if (accepted) overrun_out <= 1'b0;
        end
    end

`ifdef SLOW_CLK_MON_DUTY_EN
    logic [CNT_W-1:0] high_lat;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            high_lat <= '0;
            high_out <= '0;
        end else begin
            if ((state == ST_MEASURE) && fall) high_lat <= cnt;
            if (new_result) high_out <= high_lat;
        end
    end
`else
    logic fall_unused;

    assign fall_unused = fall;
    assign high_out    = '0;
`endif

endmodule

// File: tb/tb_slow_clk_monitor.sv
// Directed scoreboard bench for slow_clk_monitor (TIMEOUT=1000, clk_in period 10ns).
module tb_slow_clk_monitor;

    localparam int CNT_W   = 32;
    localparam int TIMEOUT = 1000;

    typedef struct packed {
        logic [31:0] period;
        logic [31:0] high;
    } result_t;

    logic             clk_in  = 1'b0;
    logic             rst_n   = 1'b0;
    logic             slow_in = 1'b0;
    logic             ack_in  = 1'b0;
    logic [CNT_W-1:0] period_out;
    logic [CNT_W-1:0] high_out;
    logic             valid_out;
    logic             overrun_out;
    logic             lost_out;

    result_t exp_q[$];
    int      checks    = 0;
    int      errors    = 0;
    int      tb_cycle  = 0;
    bit      armed     = 1'b0;
    int      last_rise = 0;
    int      last_fall = 0;

    slow_clk_monitor #(
        .CNT_W       (CNT_W),
        .TIMEOUT     (TIMEOUT),
        .SYNC_STAGES (2)
    ) dut (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .slow_in     (slow_in),
        .period_out  (period_out),
        .high_out    (high_out),
        .valid_out   (valid_out),
        .ack_in      (ack_in),
        .overrun_out (overrun_out),
        .lost_out    (lost_out)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) tb_cycle <= tb_cycle + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    // Every armed rise closes a period; its expected result goes onto the scoreboard.
    task automatic set_slow(input logic v);
        result_t r;
        if (v && !slow_in) begin
            if (armed) begin
                r.period = 32'(tb_cycle - last_rise);
`ifdef SLOW_CLK_MON_DUTY_EN
                r.high = 32'(last_fall - last_rise);
`else
                r.high = 32'd0;
`endif
                exp_q.push_back(r);
            end
            armed     = 1'b1;
            last_rise = tb_cycle;
        end else if (!v && slow_in) begin
            last_fall = tb_cycle;
        end
        slow_in = v;
    endtask

    task automatic apply_stimulus(input int high_cycles, input int low_cycles, input int n);
        repeat (n) begin
            set_slow(1'b1);
            cycles(high_cycles);
            set_slow(1'b0);
            cycles(low_cycles);
        end
    endtask

    task automatic ack_pulse();
        ack_in = 1'b1;
        cycles(1);
        ack_in = 1'b0;
    endtask

    task automatic check_output(input string tag, input logic exp_valid, input logic exp_overrun);
        result_t e;
        int      waited;
        waited = 0;
        if (exp_valid) begin
            while (valid_out !== 1'b1 && waited < 50) begin
                cycles(1);
                waited++;
            end
        end
        check({tag, ".valid"}, 32'(valid_out), 32'(exp_valid));
        check({tag, ".overrun"}, 32'(overrun_out), 32'(exp_overrun));
        if (exp_valid) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("[TB] FAIL %s.scoreboard: observed=empty expected=pending result", tag);
            end
            if (exp_q.size() > 0) begin
                while (exp_q.size() > 1) void'(exp_q.pop_front());
                e = exp_q.pop_front();
                check({tag, ".period"}, period_out, e.period);
                check({tag, ".high"}, high_out, e.high);
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".period"}, period_out, 32'd0);
        check({tag, ".high"}, high_out, 32'd0);
        check({tag, ".valid"}, 32'(valid_out), 32'd0);
        check({tag, ".overrun"}, 32'(overrun_out), 32'd0);
        check({tag, ".lost"}, 32'(lost_out), 32'd0);
    endtask

    initial begin
        cycles(2);
        check_all_zero("reset");
        rst_n = 1'b1;
        cycles(2);

        $display("[TB] 50%% duty, toggle every 5 cycles");
        apply_stimulus(5, 5, 2);
        check_output("duty50", 1'b1, 1'b0);
        ack_pulse();
        check_output("duty50_ack", 1'b0, 1'b0);

        $display("[TB] 3 high / 7 low, two results without ack");
        apply_stimulus(3, 7, 2);
        check_output("duty30_overrun", 1'b1, 1'b1);
        ack_pulse();
        check_output("duty30_ack", 1'b0, 1'b0);

        $display("[TB] overrun keeps latest result");
        apply_stimulus(4, 8, 2);
        check_output("latest", 1'b1, 1'b1);
        ack_pulse();
        check_output("latest_ack", 1'b0, 1'b0);

        $display("[TB] ack in the same cycle as a new result");
        apply_stimulus(5, 5, 1);
        check_output("pre_same_ack", 1'b1, 1'b0);
        set_slow(1'b1);
        cycles(2);
        ack_in = 1'b1;
        cycles(1);
        ack_in = 1'b0;
        cycles(2);
        set_slow(1'b0);
        cycles(5);
        check_output("same_cycle_ack", 1'b1, 1'b0);

        $display("[TB] slow clock stuck low");
        while (tb_cycle < last_rise + TIMEOUT) cycles(1);
        check("lost_early", 32'(lost_out), 32'd0);
        while (tb_cycle < last_rise + TIMEOUT + 10) cycles(1);
        check("lost", 32'(lost_out), 32'd1);
        check("lost_valid", 32'(valid_out), 32'd0);
        armed = 1'b0;
        exp_q.delete();

        $display("[TB] resume after loss");
        apply_stimulus(5, 5, 1);
        check("rearm_lost", 32'(lost_out), 32'd0);
        check("rearm_valid", 32'(valid_out), 32'd0);
        apply_stimulus(5, 5, 1);
        check_output("resume", 1'b1, 1'b0);

        $display("[TB] asynchronous reset mid-period");
        set_slow(1'b1);
        cycles(2);
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        set_slow(1'b0);
        armed = 1'b0;
        exp_q.delete();
        cycles(3);
        rst_n = 1'b1;
        cycles(3);
        apply_stimulus(5, 5, 1);
        check("post_reset_first_rise", 32'(valid_out), 32'd0);
        apply_stimulus(5, 5, 1);
        check_output("post_reset", 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
